// File: rtl/constants_pkg.sv
// Architectural constants shared across the core.
package constants_pkg;

    localparam int REG_FILE_LEN = 32;
    localparam int REG_IDX_W    = $clog2(REG_FILE_LEN);

endpackage

// File: rtl/structure_pkg.sv
// Shared decode/bypass types and the in-flight slot record used by the hazard logic.
package structure_pkg;

    import constants_pkg::*;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Decoded instruction as presented by decode. reg_data_ready is 0 for
    // results that only exist after MEM (loads, multi-cycle ops).
    typedef struct packed {
        logic     valid;
        logic     reg_write_enable;
        logic     reg_data_ready;
        reg_idx_t dst_reg;
        reg_idx_t src_reg_1;
        reg_idx_t src_reg_2;
        logic     is_r;
        logic     is_s;
        logic     is_b;
        logic     is_u;
        logic     is_j;
    } inst_decoded_t;

    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dst_reg;
        logic     data_ready;
    } inflight_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam inflight_t INFLIGHT_BUBBLE = '0;

    // Writes to x0 are architecturally discarded, so they never occupy a slot.
    function automatic inflight_t to_inflight(input logic     valid,
                                              input logic     we,
                                              input reg_idx_t dst,
                                              input logic     ready);
        inflight_t r;
        r.valid      = valid && we && (dst != '0);
        r.dst_reg    = dst;
        r.data_ready = ready;
        return r;
    endfunction

    // Any result is available by the time its producer reaches WB.
    function automatic inflight_t age_to_wb(input inflight_t s);
        inflight_t r;
        r            = s;
        r.data_ready = 1'b1;
        return r;
    endfunction

    function automatic logic src1_used(input logic is_u, input logic is_j);
        return !(is_u || is_j);
    endfunction

    function automatic logic src2_used(input logic is_r, input logic is_s, input logic is_b);
        return is_r || is_s || is_b;
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Picks the forwarding source for one operand: youngest in-flight producer wins.
module fwd_src_select
    import structure_pkg::*;
(
    input  reg_idx_t  src_reg_i,
    input  logic      used_i,
    input  inflight_t slot_exe_i,
    input  inflight_t slot_mem_i,
    input  inflight_t slot_wb_i,
    output fwd_sel_e  sel_o,
    output logic      needs_stall_o
);

    // Priority search EXE > MEM > WB; stall when the winning producer has no data yet.
    always_comb begin
        sel_o         = FWD_RF;
        needs_stall_o = 1'b0;
        if (used_i && (src_reg_i != '0)) begin
            if (slot_exe_i.valid && (slot_exe_i.dst_reg == src_reg_i)) begin
                sel_o         = FWD_EXE;
                needs_stall_o = !slot_exe_i.data_ready;
            end else if (slot_mem_i.valid && (slot_mem_i.dst_reg == src_reg_i)) begin
                sel_o         = FWD_MEM;
                needs_stall_o = !slot_mem_i.data_ready;
            end else if (slot_wb_i.valid && (slot_wb_i.dst_reg == src_reg_i)) begin
                sel_o         = FWD_WB;
                needs_stall_o = !slot_wb_i.data_ready;
            end
        end
    end

endmodule

// File: rtl/hazard_bypass_unit.sv
// Decode-side hazard unit: tracks EXE/MEM/WB destinations, drives operand
// forward selects, and raises a load-use stall with a saturating stall counter.
module hazard_bypass_unit
    import structure_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  inst_decoded_t          dec_inst_i,
    input  logic                   pipe_hold_i,
    input  logic                   flush_i,
    output bypass_t                byp_o,
    output logic [1:0]             src1_sel_o,
    output logic [1:0]             src2_sel_o,
    output logic                   stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    inflight_t exe_q, exe_d;
    inflight_t mem_q, mem_d;
    inflight_t wb_q,  wb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_e  sel1, sel2;
    logic      stall1, stall2;
    inflight_t dec_entry;

    fwd_src_select u_sel_src1 (
        .src_reg_i     (dec_inst_i.src_reg_1),
        .used_i        (src1_used(dec_inst_i.is_u, dec_inst_i.is_j)),
        .slot_exe_i    (exe_q),
        .slot_mem_i    (mem_q),
        .slot_wb_i     (wb_q),
        .sel_o         (sel1),
        .needs_stall_o (stall1)
    );

    fwd_src_select u_sel_src2 (
        .src_reg_i     (dec_inst_i.src_reg_2),
        .used_i        (src2_used(dec_inst_i.is_r, dec_inst_i.is_s, dec_inst_i.is_b)),
        .slot_exe_i    (exe_q),
        .slot_mem_i    (mem_q),
        .slot_wb_i     (wb_q),
        .sel_o         (sel2),
        .needs_stall_o (stall2)
    );

    assign src1_sel_o     = sel1;
    assign src2_sel_o     = sel2;
    assign byp_o.dep_src1 = (sel1 != FWD_RF);
    assign byp_o.dep_src2 = (sel2 != FWD_RF);

    // A squashed decode slot cannot stall anything.
    assign stall_o     = dec_inst_i.valid && !flush_i && (stall1 || stall2);
    assign stall_cnt_o = stall_cnt_q;

    assign dec_entry = to_inflight(dec_inst_i.valid, dec_inst_i.reg_write_enable,
                                   dec_inst_i.dst_reg, dec_inst_i.reg_data_ready);

    // Slot advance: flush only kills the EXE entry; older slots keep honouring the hold.
    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (flush_i) begin
            exe_d = INFLIGHT_BUBBLE;
            if (!pipe_hold_i) begin
                mem_d = exe_q;
                wb_d  = age_to_wb(mem_q);
            end
        end else if (!pipe_hold_i) begin
            wb_d  = age_to_wb(mem_q);
            mem_d = exe_q;
            exe_d = (stall_o || !dec_inst_i.valid) ? INFLIGHT_BUBBLE : dec_entry;
        end
    end

    // Stall-cycle counter: counts only cycles that actually inserted a bubble, sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && !pipe_hold_i && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // State registers; reset clears the slots at once so a pending stall drops immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q       <= INFLIGHT_BUBBLE;
            mem_q       <= INFLIGHT_BUBBLE;
            wb_q        <= INFLIGHT_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Self-checking bench for hazard_bypass_unit: directed vector table,
// hand-written hold/reset sequences, and randomized traffic against a reference model.
module tb_hazard_bypass_unit;

    import constants_pkg::*;
    import structure_pkg::*;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    localparam int K_NOP = 0, K_ALU_R = 1, K_ALU_I = 2, K_LOAD = 3, K_LUI = 4,
                   K_STORE = 5, K_BR = 6, K_JAL = 7, K_MUL = 8;

    logic          clk = 1'b0;
    logic          rst;
    inst_decoded_t dec_inst;
    logic          pipe_hold;
    logic          flush;
    bypass_t       byp;
    logic [1:0]    s1sel, s2sel;
    logic          stall;
    logic [CW-1:0] cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_bypass_unit #(.STALL_CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_inst_i  (dec_inst),
        .pipe_hold_i (pipe_hold),
        .flush_i     (flush),
        .byp_o       (byp),
        .src1_sel_o  (s1sel),
        .src2_sel_o  (s2sel),
        .stall_o     (stall),
        .stall_cnt_o (cnt)
    );

    function automatic inst_decoded_t mk(int kind, int dst, int s1, int s2);
        inst_decoded_t d = '0;
        d.valid     = (kind != K_NOP);
        d.dst_reg   = reg_idx_t'(dst);
        d.src_reg_1 = reg_idx_t'(s1);
        d.src_reg_2 = reg_idx_t'(s2);
        case (kind)
            K_ALU_R: begin d.is_r = 1; d.reg_write_enable = 1; d.reg_data_ready = 1; end
            K_ALU_I: begin d.reg_write_enable = 1; d.reg_data_ready = 1; end
            K_LOAD:  begin d.reg_write_enable = 1; d.reg_data_ready = 0; end
            K_LUI:   begin d.is_u = 1; d.reg_write_enable = 1; d.reg_data_ready = 1; end
            K_STORE: begin d.is_s = 1; end
            K_BR:    begin d.is_b = 1; end
            K_JAL:   begin d.is_j = 1; d.reg_write_enable = 1; d.reg_data_ready = 1; end
            K_MUL:   begin d.is_r = 1; d.reg_write_enable = 1; d.reg_data_ready = 0; end
            default: ;
        endcase
        return d;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_outs(string tag, int e1, int e2, int est, int ecnt);
        chk({tag, " sel1"},  int'(s1sel), e1);
        chk({tag, " sel2"},  int'(s2sel), e2);
        chk({tag, " dep1"},  int'(byp.dep_src1), int'(e1 != 0));
        chk({tag, " dep2"},  int'(byp.dep_src2), int'(e2 != 0));
        chk({tag, " stall"}, int'(stall), est);
        chk({tag, " cnt"},   int'(cnt), ecnt);
    endtask

    // Drive one decode cycle at posedge+1, check at posedge+5, then cross the edge.
    task automatic step(string tag, int kind, int dst, int s1, int s2, bit hold, bit fl,
                        int e1, int e2, int est, int ecnt);
        dec_inst  = mk(kind, dst, s1, s2);
        pipe_hold = hold;
        flush     = fl;
        #4;
        chk_outs(tag, e1, e2, est, ecnt);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int kind; int dst; int s1; int s2;
        bit hold; bit fl;
        int sel1; int sel2; int stall; int cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB.
    typedef struct { bit v; int dst; bit slow; } mslot_t;
    mslot_t pipe[3];
    int     m_cnt;

    function automatic int m_sel(int src, bit used);
        if (!used || src == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].dst == src) return k + 1;
        return 0;
    endfunction

    function automatic bit m_waiting(int sel);
        if (sel == 0) return 0;
        return pipe[sel-1].slow && (sel - 1) != 2;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0};
        m_cnt = 0;
    endtask

    initial begin
        rst       = 1'b1;
        dec_inst  = '0;
        pipe_hold = 1'b0;
        flush     = 1'b0;

        //           kind     dst s1  s2  hld fl  sel1 sel2 stl cnt
        vecs.push_back('{K_NOP,    0,  0,  0, 0, 0,  0, 0, 0, 0});
        vecs.push_back('{K_ALU_R,  5,  1,  2, 0, 0,  0, 0, 0, 0});
        vecs.push_back('{K_ALU_R,  6,  5,  7, 0, 0,  1, 0, 0, 0});
        vecs.push_back('{K_LOAD,   8,  1,  6, 0, 0,  0, 0, 0, 0});
        vecs.push_back('{K_ALU_R,  9,  8,  8, 0, 0,  1, 1, 1, 0});
        vecs.push_back('{K_ALU_R,  9,  8,  8, 0, 0,  2, 2, 1, 1});
        vecs.push_back('{K_ALU_R,  9,  8,  8, 0, 0,  3, 3, 0, 2});
        vecs.push_back('{K_ALU_I,  0,  9,  0, 0, 0,  1, 0, 0, 2});
        vecs.push_back('{K_ALU_R, 10,  0,  9, 0, 0,  0, 2, 0, 2});
        vecs.push_back('{K_LUI,   11, 10,  9, 0, 0,  0, 0, 0, 2});
        vecs.push_back('{K_LOAD,  12,  0,  0, 0, 0,  0, 0, 0, 2});
        vecs.push_back('{K_ALU_R, 13, 12, 11, 0, 1,  1, 2, 0, 2});
        vecs.push_back('{K_ALU_R, 14, 13,  0, 0, 0,  0, 0, 0, 2});
        vecs.push_back('{K_ALU_R, 15, 12, 14, 0, 0,  3, 1, 0, 2});
        vecs.push_back('{K_LOAD,  16,  0,  0, 0, 0,  0, 0, 0, 2});
        vecs.push_back('{K_ALU_R, 17,  1,  2, 0, 0,  0, 0, 0, 2});
        vecs.push_back('{K_ALU_R, 18, 16, 17, 0, 0,  2, 1, 1, 2});
        vecs.push_back('{K_ALU_R, 18, 16, 17, 0, 0,  3, 2, 0, 3});
        vecs.push_back('{K_STORE,  0, 18, 17, 0, 0,  1, 3, 0, 3});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("v%0d", i), vecs[i].kind, vecs[i].dst, vecs[i].s1, vecs[i].s2,
                 vecs[i].hold, vecs[i].fl, vecs[i].sel1, vecs[i].sel2, vecs[i].stall, vecs[i].cnt);

        // Load in EXE under a downstream hold: everything frozen, counter idle.
        step("h_lw", K_LOAD, 5, 0, 0, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++)
            step($sformatf("h_hold%0d", i), K_ALU_R, 6, 5, 5, 1, 0, 1, 1, 1, 3);
        step("h_rel0", K_ALU_R, 6, 5, 5, 0, 0, 1, 1, 1, 3);
        step("h_rel1", K_ALU_R, 6, 5, 5, 0, 0, 2, 2, 1, 4);
        step("h_rel2", K_ALU_R, 6, 5, 5, 0, 0, 3, 3, 0, 5);

        // Reset mid-stream drops a pending stall without waiting for a clock.
        step("r_lw", K_LOAD, 7, 0, 0, 0, 0, 0, 0, 0, 5);
        dec_inst = mk(K_ALU_R, 8, 7, 0);
        #4;
        chk("r_pre stall", int'(stall), 1);
        rst = 1'b1;
        #1;
        chk_outs("r_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model, with periodic resets so the
        // counter both climbs and saturates.
        m_clear();
        for (int i = 0; i < 3000; i++) begin
            int  kind, dst, s1, s2, e1, e2;
            bit  hold, fl, u1, u2, vld, est;
            if (i % 250 == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                m_clear();
            end else begin
                #1;
            end
            kind = $urandom_range(0, 8);
            dst  = $urandom_range(0, 7);
            s1   = $urandom_range(0, 7);
            s2   = $urandom_range(0, 7);
            hold = ($urandom_range(0, 99) < 15);
            fl   = ($urandom_range(0, 99) < 10);
            dec_inst  = mk(kind, dst, s1, s2);
            pipe_hold = hold;
            flush     = fl;
            #3;

            vld = (kind != K_NOP);
            u1  = !(kind == K_LUI || kind == K_JAL);
            u2  = (kind == K_ALU_R || kind == K_MUL || kind == K_STORE || kind == K_BR);
            e1  = m_sel(s1, u1);
            e2  = m_sel(s2, u2);
            est = vld && !fl && (m_waiting(e1) || m_waiting(e2));
            chk_outs($sformatf("rnd%0d", i), e1, e2, int'(est), m_cnt);

            @(posedge clk);
            if (est && !hold && m_cnt < CNTMAX) m_cnt++;
            if (fl) begin
                if (!hold) begin
                    pipe[2] = pipe[1];
                    pipe[1] = pipe[0];
                end
                pipe[0] = '{0, 0, 0};
            end else if (!hold) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (est || !vld) pipe[0] = '{0, 0, 0};
                else pipe[0] = '{(kind == K_ALU_R || kind == K_ALU_I || kind == K_LOAD ||
                                  kind == K_LUI || kind == K_JAL || kind == K_MUL) && dst != 0,
                                 dst, (kind == K_LOAD || kind == K_MUL)};
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
